// File: rtl/sonar_responder.sv
// HC-SR04-style ultrasonic sensor emulator: qualifies a trig pulse, waits a burst delay, then emits an echo.
// Optional macro SONAR_RESPONDER_CLAMP_EN clamps the captured echo width to MAX_ECHO.
module sonar_responder #(
  parameter int unsigned MIN_TRIG    = 100,
  parameter int unsigned BURST_DELAY = 5400,
  parameter int unsigned HOLDOFF     = 1200,
  parameter int unsigned MAX_ECHO    = 456000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        trig,
  input  logic [31:0] echo_width,
  output logic        echo,
  output logic        busy,
  output logic        trig_err,
  output logic [15:0] pulse_count
);

`ifdef SONAR_RESPONDER_CLAMP_EN
  localparam bit CLAMP_EN = 1'b1;
`else
  localparam bit CLAMP_EN = 1'b0;
`endif

  localparam logic [31:0] MIN_TRIG_W = 32'(MIN_TRIG);
  localparam logic [31:0] BURST_LAST = 32'(BURST_DELAY - 1);
  localparam logic [31:0] HOLD_LAST  = 32'(HOLDOFF - 1);
  localparam logic [31:0] MAX_ECHO_W = 32'(MAX_ECHO);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_BURST = 3'd2,
    ST_ECHO  = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

  state_t      state_r, state_nxt_s;
  logic        trig_meta_r, trig_s_r;
  logic [31:0] high_cnt_r, high_cnt_nxt_s;
  logic [31:0] phase_r, phase_nxt_s;
  logic [31:0] width_r, width_nxt_s;
  logic [15:0] count_r, count_nxt_s;
  logic        trig_err_r, trig_err_nxt_s;
  logic        echo_r, busy_r;

  function automatic logic [31:0] capture_width(input logic [31:0] req);
    logic [31:0] w;
    if (CLAMP_EN && (req > MAX_ECHO_W)) begin
      w = MAX_ECHO_W;
    end else begin
      w = req;
    end
    return w;
  endfunction

  // Two-flop synchronizer for the asynchronous trig input
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trig_meta_r <= 1'b0;
      trig_s_r    <= 1'b0;
    end else begin
      trig_meta_r <= trig;
      trig_s_r    <= trig_meta_r;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      high_cnt_r <= 32'd0;
      phase_r    <= 32'd0;
      width_r    <= 32'd0;
      count_r    <= 16'd0;
      trig_err_r <= 1'b0;
      echo_r     <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      high_cnt_r <= high_cnt_nxt_s;
      phase_r    <= phase_nxt_s;
      width_r    <= width_nxt_s;
      count_r    <= count_nxt_s;
      trig_err_r <= trig_err_nxt_s;
      // echo trails the ECHO state by one cycle, which gives the extra latency cycle
      echo_r     <= (state_r == ST_ECHO);
      busy_r     <= (state_nxt_s != ST_IDLE);
    end
  end

  // Next-state and counter update logic
  always_comb begin
    state_nxt_s    = state_r;
    high_cnt_nxt_s = high_cnt_r;
    phase_nxt_s    = phase_r;
    width_nxt_s    = width_r;
    count_nxt_s    = count_r;
    trig_err_nxt_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (trig_s_r) begin
          state_nxt_s    = ST_ARMED;
          high_cnt_nxt_s = 32'd1;
        end else begin
          high_cnt_nxt_s = 32'd0;
        end
      end
      ST_ARMED: begin
        if (trig_s_r) begin
          if (high_cnt_r != 32'hFFFF_FFFF) begin
            high_cnt_nxt_s = high_cnt_r + 32'd1;
          end else begin
            high_cnt_nxt_s = high_cnt_r;
          end
        end else if (high_cnt_r >= MIN_TRIG_W) begin
          width_nxt_s    = capture_width(echo_width);
          phase_nxt_s    = 32'd0;
          high_cnt_nxt_s = 32'd0;
          state_nxt_s    = ST_BURST;
        end else begin
          trig_err_nxt_s = 1'b1;
          high_cnt_nxt_s = 32'd0;
          state_nxt_s    = ST_IDLE;
        end
      end
      ST_BURST: begin
        if (phase_r == BURST_LAST) begin
          phase_nxt_s = 32'd0;
          if (width_r == 32'd0) begin
            state_nxt_s = ST_HOLD;
          end else begin
            state_nxt_s = ST_ECHO;
          end
        end else begin
          phase_nxt_s = phase_r + 32'd1;
        end
      end
      ST_ECHO: begin
        if (phase_r == (width_r - 32'd1)) begin
          phase_nxt_s = 32'd0;
          count_nxt_s = count_r + 16'd1;
          state_nxt_s = ST_HOLD;
        end else begin
          phase_nxt_s = phase_r + 32'd1;
        end
      end
      ST_HOLD: begin
        // Holdoff counter saturates; a still-high trig keeps us here until release
        if (phase_r >= HOLD_LAST) begin
          if (!trig_s_r) begin
            phase_nxt_s = 32'd0;
            state_nxt_s = ST_IDLE;
          end else begin
            phase_nxt_s = phase_r;
          end
        end else begin
          phase_nxt_s = phase_r + 32'd1;
        end
      end
      default: begin
        state_nxt_s    = ST_IDLE;
        phase_nxt_s    = 32'd0;
        high_cnt_nxt_s = 32'd0;
      end
    endcase
  end

  assign echo        = echo_r;
  assign busy        = busy_r;
  assign trig_err    = trig_err_r;
  assign pulse_count = count_r;

endmodule

// File: tb/tb_sonar_responder.sv
// Directed self-checking bench for sonar_responder (MIN_TRIG=100, BURST_DELAY=50, HOLDOFF=20, MAX_ECHO=1000).
module tb_sonar_responder;
  logic        clk;
  logic        reset;
  logic        trig;
  logic [31:0] echo_width;
  logic        echo;
  logic        busy;
  logic        trig_err;
  logic [15:0] pulse_count;

  int total = 0;
  int bad   = 0;
  int err_seen = 0;
  int c;
  int w;
  int b;
  logic echo_hit;

`ifdef SONAR_RESPONDER_CLAMP_EN
  localparam int LONG_EXP = 1000;
`else
  localparam int LONG_EXP = 5000;
`endif

  sonar_responder #(
    .MIN_TRIG(100), .BURST_DELAY(50), .HOLDOFF(20), .MAX_ECHO(1000)
  ) dut (
    .clk(clk), .reset(reset), .trig(trig), .echo_width(echo_width),
    .echo(echo), .busy(busy), .trig_err(trig_err), .pulse_count(pulse_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (trig_err === 1'b1) err_seen <= err_seen + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // trig high for n sampled cycles, then returns just after the edge that first samples it low
  task automatic send_trig(input int n);
    trig = 1'b1;
    repeat (n) tick();
    trig = 1'b0;
    tick();
  endtask

  task automatic wait_rise(output int cyc);
    cyc = 0;
    while (echo !== 1'b1 && cyc < 20000) begin tick(); cyc++; end
  endtask

  task automatic meas_width(output int wid);
    wid = 0;
    while (echo === 1'b1 && wid < 20000) begin tick(); wid++; end
  endtask

  task automatic wait_idle(output int cyc, output logic saw_echo);
    cyc = 0;
    saw_echo = 1'b0;
    while (busy === 1'b1 && cyc < 20000) begin
      tick(); cyc++;
      if (echo === 1'b1) saw_echo = 1'b1;
    end
  endtask

  initial begin
    reset = 1'b1; trig = 1'b0; echo_width = 32'd0;
    repeat (3) tick();
    chk("rst_echo", {31'd0, echo}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, trig_err}, 32'd0);
    chk("rst_count", {16'd0, pulse_count}, 32'd0);
    reset = 1'b0;
    repeat (2) tick();

    // valid trig, width 300; width change after capture must not matter
    echo_width = 32'd300;
    send_trig(120);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    repeat (5) tick();
    echo_width = 32'd9;
    wait_rise(c);
    chk("t1_latency", c + 5, 32'd53);
    meas_width(w);
    chk("t1_width", w, 32'd300);
    chk("t1_count", {16'd0, pulse_count}, 32'd1);
    wait_idle(b, echo_hit);
    chk("t1_holdoff", b, 32'd19);

    // short trig -> single trig_err pulse
    send_trig(60);
    chk("t2_err_e1", {31'd0, trig_err}, 32'd0);
    tick();
    chk("t2_err_e2", {31'd0, trig_err}, 32'd0);
    tick();
    chk("t2_err_pulse", {31'd0, trig_err}, 32'd1);
    chk("t2_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("t2_err_clear", {31'd0, trig_err}, 32'd0);
    chk("t2_echo", {31'd0, echo}, 32'd0);
    chk("t2_count", {16'd0, pulse_count}, 32'd1);
    repeat (3) tick();

    // zero width: busy 2+50+20 cycles, no echo
    echo_width = 32'd0;
    send_trig(110);
    wait_idle(b, echo_hit);
    chk("t3_busy_len", b, 32'd72);
    chk("t3_no_echo", {31'd0, echo_hit}, 32'd0);
    chk("t3_count", {16'd0, pulse_count}, 32'd1);
    repeat (3) tick();

    // second trig during ECHO is ignored; third trig after HOLD works
    echo_width = 32'd300;
    send_trig(120);
    wait_rise(c);
    chk("t4_latency", c, 32'd53);
    repeat (10) tick();
    send_trig(120);
    meas_width(w);
    chk("t4_width", w + 131, 32'd300);
    chk("t4_count", {16'd0, pulse_count}, 32'd2);
    wait_idle(b, echo_hit);
    chk("t4_holdoff", b, 32'd19);
    chk("t4_no_retrig", {31'd0, echo_hit}, 32'd0);
    repeat (5) tick();
    echo_width = 32'd40;
    send_trig(120);
    wait_rise(c);
    chk("t4_third_lat", c, 32'd53);
    meas_width(w);
    chk("t4_third_width", w, 32'd40);
    chk("t4_third_count", {16'd0, pulse_count}, 32'd3);
    wait_idle(b, echo_hit);

    // reset in the middle of a 300-cycle echo
    echo_width = 32'd300;
    send_trig(120);
    wait_rise(c);
    chk("t5_latency", c, 32'd53);
    repeat (100) tick();
    chk("t5_echo_mid", {31'd0, echo}, 32'd1);
    reset = 1'b1;
    #1;
    chk("t5_echo_async", {31'd0, echo}, 32'd0);
    chk("t5_count", {16'd0, pulse_count}, 32'd0);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    // boundary: exactly MIN_TRIG is accepted
    echo_width = 32'd25;
    send_trig(100);
    wait_rise(c);
    chk("t5_min_latency", c, 32'd53);
    meas_width(w);
    chk("t5_min_width", w, 32'd25);
    chk("t5_min_count", {16'd0, pulse_count}, 32'd1);
    wait_idle(b, echo_hit);
    // boundary: MIN_TRIG-1 is rejected
    send_trig(99);
    repeat (2) tick();
    chk("t5_99_err", {31'd0, trig_err}, 32'd1);
    repeat (3) tick();

    // long requested width, clamped only when the macro is defined; long trig keeps echo low
    echo_width = 32'd5000;
    send_trig(300);
    chk("t6_echo_low", {31'd0, echo}, 32'd0);
    wait_rise(c);
    chk("t6_latency", c, 32'd53);
    meas_width(w);
    chk("t6_width", w, LONG_EXP);
    chk("t6_count", {16'd0, pulse_count}, 32'd2);
    wait_idle(b, echo_hit);
    tick();
    chk("err_pulses", err_seen, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sonar_responder.md
SONAR_RESPONDER -- requirements
Module: sonar_responder

Interface
REQ-001 Parameter MIN_TRIG, default 100: minimum trig high time, in clk cycles, for the trigger to be accepted.
REQ-002 Parameter BURST_DELAY, default 5400: cycles from trigger acceptance to echo rise, emulating the transducer burst.
REQ-003 Parameter HOLDOFF, default 1200: cycles after echo fall before a new trigger is accepted.
REQ-004 Parameter MAX_ECHO, default 456000: echo width clamp, used only when the configuration macro is defined.
REQ-005 clk  input  1  sole clock; all logic is on the rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 trig  input  1  asynchronous trigger from the sensor driver; synchronized internally.
REQ-008 echo_width  input  32  requested echo high time in cycles; sampled at trigger acceptance.
REQ-009 echo  output  1  emulated echo pulse; registered.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 trig_err  output  1  one-cycle pulse when a trig high period shorter than MIN_TRIG ends.
REQ-012 pulse_count  output  16  number of echo pulses completed; wraps from 0xFFFF to 0.

Function
REQ-013 trig shall pass through a 2-flop synchronizer; trig_s denotes the second flop, and a fall is trig_s going from 1 to 0.
REQ-014 The FSM shall have the states IDLE, ARMED, BURST, ECHO and HOLD.
REQ-015 IDLE: on trig_s=1, go to ARMED and set the 32-bit high counter to 1.
REQ-016 ARMED: while trig_s=1, increment the high counter, saturating at 0xFFFFFFFF.
REQ-017 ARMED, fall with counter >= MIN_TRIG: capture echo_width, clear the phase counter and go to BURST.
REQ-018 ARMED, fall with counter < MIN_TRIG: pulse trig_err on the next cycle and return to IDLE.
REQ-019 BURST: stay exactly BURST_DELAY cycles, then go to ECHO with echo=1.
REQ-020 BURST, captured width = 0: go directly to HOLD instead; no echo pulse and no count increment.
REQ-021 ECHO: hold echo=1 for exactly the captured-width cycles, then echo=0, increment pulse_count and go to HOLD.
REQ-022 HOLD: stay HOLDOFF cycles, then return to IDLE only if trig_s=0; otherwise wait in HOLD until trig_s=0.
REQ-023 Trig activity in BURST, ECHO or HOLD shall be ignored and shall not produce trig_err.
REQ-024 A trig held high indefinitely shall keep the FSM in ARMED with echo low; on release, REQ-017 applies.
REQ-025 Latency: echo rises 2 + BURST_DELAY + 1 cycles after the clk edge that first samples trig low on a qualifying pulse.
REQ-026 Changes to echo_width after capture shall have no effect on the current pulse.

Reset
REQ-027 Reset shall asynchronously force echo=0, busy=0, trig_err=0, pulse_count=0, state IDLE, all counters 0 and both synchronizer flops 0.
REQ-028 Reset during ECHO shall drop echo immediately, without waiting for a clock edge, and shall not increment pulse_count.

Configuration
REQ-029 Macro SONAR_RESPONDER_CLAMP_EN defined: the captured width is min(echo_width, MAX_ECHO), emulating the sensor's no-object timeout.
REQ-030 Macro SONAR_RESPONDER_CLAMP_EN absent: the captured width equals echo_width exactly, and MAX_ECHO is unused.

Verification
Bench parameters: MIN_TRIG=100, BURST_DELAY=50, HOLDOFF=20, MAX_ECHO=1000.
REQ-031 trig high 120 cycles, echo_width=300 -> echo rises 53 cycles after the trig fall is sampled, stays high exactly 300 cycles, pulse_count=1.
REQ-032 trig high 60 cycles -> one trig_err pulse, echo stays 0, busy returns to 0, pulse_count=0.
REQ-033 echo_width=0 with a valid trig -> no echo, busy high for 2+50+20 cycles, pulse_count unchanged.
REQ-034 A second valid trig during ECHO, then a third trig 5 cycles after HOLD exits -> second ignored; third produces one echo; pulse_count=2.
REQ-035 reset asserted 100 cycles into a 300-cycle echo -> echo=0 within the same cycle, pulse_count=0; a following valid trig works normally.
REQ-036 echo_width=5000: with CLAMP_EN the echo is 1000 cycles; without it the echo is 5000 cycles.
